// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width and sequencer states.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    HOLD      = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter_pick #(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] ptr,
  output logic [NUM_PORTS-1:0]         onehot,
  output logic [$clog2(NUM_PORTS)-1:0] index,
  output logic                         any
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] sum_s;
  logic [IDX_W-1:0] cand_s;

  // Scan from the farthest offset back to ptr so the closest requester overwrites last.
  always_comb begin
    sum_s  = '0;
    cand_s = '0;
    index  = '0;
    any    = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      sum_s  = {1'b0, ptr} + SUM_W'(i);
      sum_s  = (sum_s >= SUM_W'(NUM_PORTS)) ? sum_s - SUM_W'(NUM_PORTS) : sum_s;
      cand_s = sum_s[IDX_W-1:0];
      index  = req[cand_s] ? cand_s : index;
      any    = any | req[cand_s];
    end
    onehot = NUM_PORTS'(any) << index;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART transmitter between NUM_PORTS byte requesters,
// with a per-packet lock released by the "last" flag or by an idle-owner timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int LOCK_TIMEOUT = 256
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_PORTS-1:0]             i_req_valid,
  input  logic [UART_BYTE_W*NUM_PORTS-1:0] i_req_byte,
  input  logic [NUM_PORTS-1:0]             i_req_last,
  output logic [NUM_PORTS-1:0]             o_req_ready,
  output logic [UART_BYTE_W-1:0]           o_tx_byte,
  output logic                             o_tx_dv,
  input  logic                             i_tx_active,
  input  logic                             i_tx_done,
  output logic [NUM_PORTS-1:0]             o_grant,
  output logic [$clog2(NUM_PORTS)-1:0]     o_grant_id,
  output logic                             o_busy,
  output logic                             o_lock_timeout
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
  localparam logic [NUM_PORTS-1:0] ONE_BIT  = NUM_PORTS'(1);

  arb_state_t             state_r, state_n;
  logic [NUM_PORTS-1:0]   pick_onehot_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic                   pick_any_s;
  logic                   launch_s, release_s, timeout_s;
  logic [IDX_W-1:0]       launch_id_s;
  logic [UART_BYTE_W-1:0] launch_byte_s;
  logic                   owner_valid_s;
  logic [CNT_W-1:0]       cnt_r, cnt_n;
  logic [IDX_W-1:0]       ptr_r, grant_id_r;
  logic [NUM_PORTS-1:0]   grant_r, req_ready_r;
  logic [UART_BYTE_W-1:0] tx_byte_r;
  logic                   tx_dv_r, busy_r, last_r, lock_to_r;

  function automatic logic [NUM_PORTS-1:0] onehot_of(input logic [IDX_W-1:0] idx);
    onehot_of = ONE_BIT << idx;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    next_idx = (idx == IDX_W'(NUM_PORTS - 1)) ? '0 : idx + 1'b1;
  endfunction

  rr_arbiter_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req    (i_req_valid),
    .ptr    (ptr_r),
    .onehot (pick_onehot_s),
    .index  (pick_idx_s),
    .any    (pick_any_s)
  );

  assign owner_valid_s = i_req_valid[grant_id_r];
  assign launch_byte_s = i_req_byte[UART_BYTE_W*launch_id_s +: UART_BYTE_W];

  // Sequencer state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_r <= IDLE;
    else          state_r <= state_n;
  end

  // Next state plus launch/release/timeout decisions; pick_onehot_s is unused beyond index.
  always_comb begin
    state_n     = state_r;
    launch_s    = 1'b0;
    launch_id_s = grant_id_r;
    release_s   = 1'b0;
    timeout_s   = 1'b0;
    cnt_n       = cnt_r;
    case (state_r)
      IDLE: begin
        if (!i_tx_active && pick_any_s && (pick_onehot_s != '0)) begin
          launch_s    = 1'b1;
          launch_id_s = pick_idx_s;
          state_n     = WAIT_DONE;
        end else begin
          state_n = IDLE;
        end
      end
      WAIT_DONE: begin
        if (i_tx_done) begin
          if (last_r) begin
            release_s = 1'b1;
            state_n   = IDLE;
          end else begin
            cnt_n   = '0;
            state_n = HOLD;
          end
        end else begin
          state_n = WAIT_DONE;
        end
      end
      HOLD: begin
        // An owner byte on the timeout edge is still served.
        if (owner_valid_s && !i_tx_active) begin
          launch_s    = 1'b1;
          launch_id_s = grant_id_r;
          state_n     = WAIT_DONE;
        end else if ((LOCK_TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
          timeout_s = 1'b1;
          release_s = 1'b1;
          state_n   = IDLE;
        end else begin
          cnt_n   = cnt_r + 1'b1;
          state_n = HOLD;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Capture registers, one-cycle strobes, ownership and round-robin pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_byte_r   <= '0;
      tx_dv_r     <= 1'b0;
      req_ready_r <= '0;
      grant_r     <= '0;
      grant_id_r  <= '0;
      busy_r      <= 1'b0;
      last_r      <= 1'b0;
      lock_to_r   <= 1'b0;
      ptr_r       <= '0;
      cnt_r       <= '0;
    end else begin
      tx_dv_r     <= launch_s;
      req_ready_r <= launch_s ? onehot_of(launch_id_s) : '0;
      lock_to_r   <= timeout_s;
      cnt_r       <= cnt_n;
      if (launch_s) begin
        tx_byte_r  <= launch_byte_s;
        grant_r    <= onehot_of(launch_id_s);
        grant_id_r <= launch_id_s;
        busy_r     <= 1'b1;
        last_r     <= i_req_last[launch_id_s];
      end else if (release_s) begin
        grant_r    <= '0;
        grant_id_r <= '0;
        busy_r     <= 1'b0;
        ptr_r      <= next_idx(grant_id_r);
      end else begin
        tx_byte_r <= tx_byte_r;
      end
    end
  end

  assign o_tx_byte      = tx_byte_r;
  assign o_tx_dv        = tx_dv_r;
  assign o_req_ready    = req_ready_r;
  assign o_grant        = grant_r;
  assign o_grant_id     = grant_id_r;
  assign o_busy         = busy_r;
  assign o_lock_timeout = lock_to_r;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one UART_Transmitter between NUM_PORTS byte requesters. It captures one byte from the winning requester and issues a single-cycle i_tx_dv pulse to the transmitter. It then waits for the transmitter's o_tx_done before launching the next byte. A packet lock, driven by per-port "last" flags, lets a requester send a multi-byte message without interleaving; a lock timeout recovers from stalled owners.

Parameters:
NUM_PORTS, 4, number of requesters (2..16; need not be a power of two).
LOCK_TIMEOUT, 256, cycles an unfinished packet owner may leave valid low before losing the lock; 0 = never time out.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  NUM_PORTS  per-port byte valid; hold with byte stable until acked
i_req_byte  in  8*NUM_PORTS  port k byte at [8k+7:8k]
i_req_last  in  NUM_PORTS  byte is last of packet (1 = release grant after it)
o_req_ready  out  NUM_PORTS  one-cycle one-hot ack: byte captured
o_tx_byte  out  8  to transmitter i_tx_byte
o_tx_dv  out  1  to transmitter i_tx_dv, one-cycle pulse
i_tx_active  in  1  from transmitter o_tx_active
i_tx_done  in  1  from transmitter o_tx_done
o_grant  out  NUM_PORTS  one-hot current owner, 0 when idle
o_grant_id  out  $clog2(NUM_PORTS)  binary owner index
o_busy  out  1  high from capture until grant release
o_lock_timeout  out  1  one-cycle pulse when a lock is forcibly released

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; round-robin pointer ptr=0; timeout counter 0. Reset mid-byte drops o_tx_dv/o_grant immediately; the transmitter is not reset by this block.
- States: IDLE, WAIT_DONE, HOLD.
- IDLE: when i_tx_active=0 and any i_req_valid: winner = first valid port scanning ptr, ptr+1, ... modulo NUM_PORTS. At that edge: o_tx_byte<=winner byte, o_tx_dv<=1, o_req_ready<=onehot(winner), o_grant/o_grant_id<=winner, o_busy<=1, latch last flag, go WAIT_DONE. Latency: valid sampled at edge E, dv/ready high in the cycle after E. If i_tx_active=1, no launch.
- o_tx_dv and o_req_ready are always exactly one cycle wide.
- WAIT_DONE: ignore all requests; on edge with i_tx_done=1: if latched last=1, clear grant and busy, ptr<=(owner+1) mod NUM_PORTS, go IDLE; else clear timeout counter and go HOLD.
- HOLD: only the owner is served. On an edge with owner's valid=1: launch as in IDLE (capture, dv, ready, latch last), go WAIT_DONE. Otherwise increment counter; when LOCK_TIMEOUT!=0 and counter reaches LOCK_TIMEOUT-1: pulse o_lock_timeout, clear grant/busy, ptr<=owner+1, go IDLE. A valid from the owner on the timeout edge wins over timeout.
- Grant release to next launch: minimum one IDLE cycle.
- Simultaneous requests: resolved strictly by pointer; non-owner valids never disturb a locked packet.
- Withdrawn valid before ack is legal; only the value sampled at the capture edge is sent.
- Counter width: $clog2(LOCK_TIMEOUT+1), saturating not required (reset on each HOLD entry).

Decomposition:
- Shared package uart_pkg: state encodings (IDLE, WAIT_DONE, HOLD), UART_BYTE_W=8.
- One sub-module rr_arbiter_pick: combinational round-robin picker (inputs: request vector, ptr; outputs: one-hot, index, any). The FSM, capture registers and timeout counter stay in uart_tx_arbiter.

Test Plan:
(Bench pairs the block with UART_Transmitter, CYCLES_PER_BIT=4.)
- Port 0 valid with 0xA5, last=1 -> next cycle o_tx_dv=1, o_tx_byte=0xA5, o_req_ready=0001, o_grant=0001. Serial line shows 0,1,0,1,0,0,1,0,1,1 (LSB first). After done, o_grant=0, o_busy=0.
- Ports 0 and 2 valid together, last=1, ptr=0 -> port 0 sent, then port 2. Then ports 0 and 1 valid -> ptr=3 wraps, port 0 wins.
- Port 1 packet 0x11,0x22,0x33 (last on 0x33) with port 3 valid throughout -> serial order 0x11,0x22,0x33,0x3x. Port 3 is never granted before 0x33's done.
- LOCK_TIMEOUT=16: port 1 sends 0x11 last=0, then drops valid; port 2 valid -> 16 cycles in HOLD, o_lock_timeout pulse, grant released, port 2 byte sent next.
- i_rst_n low during WAIT_DONE -> all outputs 0 same cycle. After release, port 0 valid while i_tx_active=1 -> no dv until i_tx_active=0.
- NUM_PORTS=3: port 2 owner releases, ports 0 and 2 valid -> port 0 granted (o_grant_id=0).
